// File: rtl/bf_pkg.sv
// Shared constants for the multi-lane butterfly: mode encodings, default modulus,
// Barrett constant and pipeline latency.
package bf_pkg;

    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;
    localparam logic [1:0] MODE_BP   = 2'b10;
    localparam logic [1:0] MODE_PWM  = 2'b11;

    localparam int Q_DEF = 3329;
    localparam int LAT   = 4;

    // floor(2^(2*dw) / q), the Barrett multiplier for products of two dw-bit residues
    function automatic logic [63:0] barrett_k(input int dw, input int q);
        return (64'd1 << (2 * dw)) / 64'(q);
    endfunction

    localparam logic [31:0] BARRETT_K_DEF = 32'(barrett_k(16, Q_DEF));

endpackage

// File: rtl/butterfly_pipe_n_mod_mul.sv
// Two-stage modular multiplier: full product in stage one, Barrett reduction with a
// single conditional subtract in stage two.
module mod_mul_q
    import bf_pkg::*;
#(
    parameter int DW = 16,
    parameter int Q  = Q_DEF
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] y_i,
    output logic [DW-1:0] r_o
);

    localparam int PW = 2 * DW;
    localparam logic [PW-1:0] K  = PW'(barrett_k(DW, Q));
    localparam logic [PW-1:0] QP = PW'(Q);

    logic [PW-1:0] prod_d, prod_q;
    logic [PW-1:0] qe, rem;
    logic [DW-1:0] r_d, r_q;

    // The quotient estimate is at most one low, so the remainder lands in [0, 2Q)
    always_comb begin
        prod_d = PW'(x_i) * PW'(y_i);
        qe     = PW'(({{PW{1'b0}}, prod_q} * {{PW{1'b0}}, K}) >> PW);
        rem    = prod_q - qe * QP;
        if (rem >= QP) begin
            rem = rem - QP;
        end
        r_d    = rem[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            r_q    <= '0;
        end else if (en) begin
            prod_q <= prod_d;
            r_q    <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/butterfly_pipe_n.sv
// LANES-wide NTT/INTT/bypass/pointwise butterfly, fixed latency, valid/ready both sides.
// Optional BF_INTT_HALVE_EN scales INTT outputs by 2^-1 mod Q.
module butterfly_pipe_n
    import bf_pkg::*;
#(
    parameter int DW    = 16,
    parameter int Q     = Q_DEF,
    parameter int LANES = 2
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [LANES*DW-1:0] a,
    input  logic [LANES*DW-1:0] b,
    input  logic [LANES*DW-1:0] w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] c,
    output logic [LANES*DW-1:0] d,
    output logic [1:0]          out_mode,
    output logic                busy
);

    localparam logic [DW:0]   QX = (DW+1)'(Q);
    localparam logic [DW-1:0] QD = DW'(Q);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) begin
            s = s - QX;
        end
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return (x >= y) ? (x - y) : (x - y + QD);
    endfunction

`ifdef BF_INTT_HALVE_EN
    function automatic logic [DW-1:0] halve(input logic [DW-1:0] x);
        logic [DW:0] s;
        s = {1'b0, x} + (x[0] ? QX : '0);
        return s[DW:1];
    endfunction
`endif

    logic       en;
    logic       vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic [1:0] mode_p0_q, mode_p1_q, mode_p2_q, mode_p3_q, mode_p4_q;

    assign en        = !vld_p4_q || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p4_q;
    assign out_mode  = mode_p4_q;
    assign busy      = vld_p0_q | vld_p1_q | vld_p2_q | vld_p3_q | vld_p4_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            vld_p4_q  <= 1'b0;
            mode_p0_q <= '0;
            mode_p1_q <= '0;
            mode_p2_q <= '0;
            mode_p3_q <= '0;
            mode_p4_q <= '0;
        end else if (en) begin
            vld_p0_q  <= in_valid;
            vld_p1_q  <= vld_p0_q;
            vld_p2_q  <= vld_p1_q;
            vld_p3_q  <= vld_p2_q;
            vld_p4_q  <= vld_p3_q;
            mode_p0_q <= mode;
            mode_p1_q <= mode_p0_q;
            mode_p2_q <= mode_p1_q;
            mode_p3_q <= mode_p2_q;
            mode_p4_q <= mode_p3_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] a_p0_q, b_p0_q, w_p0_q;
        logic [DW-1:0] x_p1_d, y_p1_d, x_p1_q, y_p1_q, w_p1_q;
        logic [DW-1:0] x_p2_q, y_p2_q, x_p3_q, y_p3_q;
        logic [DW-1:0] ma_p3, mb_p3;
        logic [DW-1:0] c_p4_d, d_p4_d, c_p4_q, d_p4_q;

        // p0 -> p1: INTT pre-add/sub; other modes pass the operands through
        always_comb begin
            x_p1_d = a_p0_q;
            y_p1_d = b_p0_q;
            if (mode_p0_q == MODE_INTT) begin
                x_p1_d = mod_add(a_p0_q, b_p0_q);
                y_p1_d = mod_sub(a_p0_q, b_p0_q);
            end
        end

        // p1 -> p3: both multipliers always run; the output stage picks what it needs
        mod_mul_q #(.DW(DW), .Q(Q)) u_mul_a (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .x_i   (x_p1_q),
            .y_i   (w_p1_q),
            .r_o   (ma_p3)
        );

        mod_mul_q #(.DW(DW), .Q(Q)) u_mul_b (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .x_i   (y_p1_q),
            .y_i   (w_p1_q),
            .r_o   (mb_p3)
        );

        // p3 -> p4: NTT post-add/sub, optional INTT halving, output select
        always_comb begin
            c_p4_d = x_p3_q;
            d_p4_d = y_p3_q;
            case (mode_p3_q)
                MODE_NTT: begin
                    c_p4_d = mod_add(x_p3_q, mb_p3);
                    d_p4_d = mod_sub(x_p3_q, mb_p3);
                end
                MODE_INTT: begin
`ifdef BF_INTT_HALVE_EN
                    c_p4_d = halve(x_p3_q);
                    d_p4_d = halve(mb_p3);
`else
                    c_p4_d = x_p3_q;
                    d_p4_d = mb_p3;
`endif
                end
                MODE_PWM: begin
                    c_p4_d = ma_p3;
                    d_p4_d = mb_p3;
                end
                default: begin
                    c_p4_d = x_p3_q;
                    d_p4_d = y_p3_q;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a_p0_q <= '0;
                b_p0_q <= '0;
                w_p0_q <= '0;
                x_p1_q <= '0;
                y_p1_q <= '0;
                w_p1_q <= '0;
                x_p2_q <= '0;
                y_p2_q <= '0;
                x_p3_q <= '0;
                y_p3_q <= '0;
                c_p4_q <= '0;
                d_p4_q <= '0;
            end else if (en) begin
                a_p0_q <= a[i*DW +: DW];
                b_p0_q <= b[i*DW +: DW];
                w_p0_q <= w[i*DW +: DW];
                x_p1_q <= x_p1_d;
                y_p1_q <= y_p1_d;
                w_p1_q <= w_p0_q;
                x_p2_q <= x_p1_q;
                y_p2_q <= y_p1_q;
                x_p3_q <= x_p2_q;
                y_p3_q <= y_p2_q;
                c_p4_q <= c_p4_d;
                d_p4_q <= d_p4_d;
            end
        end

        assign c[i*DW +: DW] = c_p4_q;
        assign d[i*DW +: DW] = d_p4_q;
    end

endmodule

// File: tb/tb_butterfly_pipe_n.sv
// Scoreboard bench for butterfly_pipe_n: directed vectors, backpressure, mid-stream reset
// and a random regression against an integer reference model.
module tb_butterfly_pipe_n;
    import bf_pkg::*;

    localparam int DW    = 16;
    localparam int Q     = 3329;
    localparam int LANES = 2;
    localparam int LW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [LW-1:0] a, b, w;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] c, d;
    logic [1:0]    out_mode;
    logic          busy;

    always #5 clk = ~clk;

    butterfly_pipe_n #(.DW(DW), .Q(Q), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .d         (d),
        .out_mode  (out_mode),
        .busy      (busy)
    );

    typedef struct {
        logic [LW-1:0] c;
        logic [LW-1:0] d;
        logic [1:0]    m;
        int            edge_n;
        bit            chk_lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ordy_mode = 0;
    int   stall_lo = 0;
    int   stall_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int halve_ref(input int x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction

    function automatic void model(input logic [1:0] m, input logic [LW-1:0] av, input logic [LW-1:0] bv,
                                  input logic [LW-1:0] wv, output logic [LW-1:0] ec, output logic [LW-1:0] ed);
        ec = '0;
        ed = '0;
        for (int i = 0; i < LANES; i++) begin
            int ai, bi, wi, t, ci, di;
            ai = int'(av[i*DW +: DW]);
            bi = int'(bv[i*DW +: DW]);
            wi = int'(wv[i*DW +: DW]);
            case (m)
                MODE_NTT: begin
                    t  = (bi * wi) % Q;
                    ci = (ai + t) % Q;
                    di = (ai - t + Q) % Q;
                end
                MODE_INTT: begin
                    ci = (ai + bi) % Q;
                    di = (((ai - bi + Q) % Q) * wi) % Q;
`ifdef BF_INTT_HALVE_EN
                    ci = halve_ref(ci);
                    di = halve_ref(di);
`endif
                end
                MODE_PWM: begin
                    ci = (ai * wi) % Q;
                    di = (bi * wi) % Q;
                end
                default: begin
                    ci = ai;
                    di = bi;
                end
            endcase
            ec[i*DW +: DW] = DW'(ci);
            ed[i*DW +: DW] = DW'(di);
        end
    endfunction

    function automatic logic [LW-1:0] rnd_vec();
        logic [LW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom_range(0, Q - 1));
        return v;
    endfunction

    task automatic set_ready();
        case (ordy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(cyc >= stall_lo && cyc < stall_hi);
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_ready();
            in_valid = 1'b0;
            mode     = 2'($urandom);
            a        = $urandom;
            b        = $urandom;
            w        = $urandom;
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [LW-1:0] av, input logic [LW-1:0] bv,
                        input logic [LW-1:0] wv, input logic [LW-1:0] ec, input logic [LW-1:0] ed,
                        input bit lat);
        int   tries;
        bit   done;
        exp_t e;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            set_ready();
            in_valid = 1'b1;
            mode     = m;
            a        = av;
            b        = bv;
            w        = wv;
            #1;
            if (out_valid && !out_ready) chk("in_ready_drop", 64'(in_ready), 64'd0);
            if (in_ready) begin
                e.c = ec;
                e.d = ed;
                e.m = m;
                e.edge_n = cyc + 1;
                e.chk_lat = lat;
                sbq.push_back(e);
                done = 1;
            end else if (++tries > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout in_ready=%0d required=1", in_ready);
                done = 1;
            end
        end
    endtask

    task automatic send_model(input logic [1:0] m, input logic [LW-1:0] av, input logic [LW-1:0] bv,
                              input logic [LW-1:0] wv);
        logic [LW-1:0] ec, ed;
        model(m, av, bv, wv, ec, ed);
        send(m, av, bv, wv, ec, ed, 1'b0);
    endtask

    // Monitor: compares every handshaked output against the head of the scoreboard
    initial begin : monitor
        exp_t          e;
        bit            prev_hold;
        logic [2*LW+2:0] prev;
        prev_hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_hold = 0;
                continue;
            end
            if (prev_hold) chk("hold_stable", 64'({out_valid, c, d, out_mode} == prev), 64'd1);
            prev_hold = out_valid && !out_ready;
            prev = {out_valid, c, d, out_mode};
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output c=%0h d=%0h required=none", c, d);
                end else begin
                    e = sbq.pop_front();
                    chk("c", 64'(c), 64'(e.c));
                    chk("d", 64'(d), 64'(e.d));
                    chk("out_mode", 64'(out_mode), 64'(e.m));
                    if (e.chk_lat) chk("latency_edge", 64'(cyc), 64'(e.edge_n + LAT));
                end
            end
        end
    end

    initial begin : driver
        logic [LW-1:0] ic, id;
        int            k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = '0;
        a         = '0;
        b         = '0;
        w         = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_c",         64'(c),         64'd0);
        chk("rst_d",         64'(d),         64'd0);
        chk("rst_out_mode",  64'(out_mode),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;

        // Directed hand-computed vectors (lane1 in the upper half)
        send(MODE_NTT, {16'd0, 16'd1}, {16'd0, 16'd2}, {16'd5, 16'd17},
             {16'd0, 16'd35}, {16'd0, 16'd3296}, 1'b1);
`ifdef BF_INTT_HALVE_EN
        ic = {16'd1700, 16'd1700};
        id = {16'd129, 16'd129};
`else
        ic = {16'd71, 16'd71};
        id = {16'd258, 16'd258};
`endif
        send(MODE_INTT, {16'd100, 16'd100}, {16'd3300, 16'd3300}, {16'd2, 16'd2}, ic, id, 1'b1);
        send(MODE_PWM, {16'd3328, 16'd3328}, {16'd2, 16'd2}, {16'd3328, 16'd3328},
             {16'd1, 16'd1}, {16'd3327, 16'd3327}, 1'b1);
        send(MODE_BP, {16'd9, 16'd5}, {16'd11, 16'd7}, {16'd1234, 16'd3000},
             {16'd9, 16'd5}, {16'd11, 16'd7}, 1'b1);
        idle(8);

        // Back-to-back NTT stream with a 3-cycle output stall in the middle
        ordy_mode = 2;
        stall_lo  = cyc + 7;
        stall_hi  = stall_lo + 3;
        for (int i = 0; i < 8; i++) send_model(MODE_NTT, rnd_vec(), rnd_vec(), rnd_vec());
        idle(12);
        ordy_mode = 0;
        idle(2);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) send_model(MODE_PWM, rnd_vec(), rnd_vec(), rnd_vec());
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sbq.delete();
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_c",         64'(c),         64'd0);
        chk("midrst_d",         64'(d),         64'd0);
        rst_n = 1'b1;
        idle(10);

        // Random regression with random bubbles and random downstream backpressure
        ordy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_model(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), rnd_vec());
        end
        ordy_mode = 0;
        k = 0;
        while (sbq.size() != 0 && k < 200) begin
            idle(1);
            k++;
        end
        idle(3);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        chk("final_busy",  64'(busy),       64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe_n.md
Name: butterfly_pipe_n

Overview:
- Parametrised, multi-lane successor to the Kyber butterfly. LANES independent butterflies run in lockstep, and every lane shares one mode per transaction.
- Modes: Cooley-Tukey NTT, Gentleman-Sande INTT, bypass, and coefficient-wise multiply by twiddle.
- Fixed latency, with a valid/ready handshake on both sides and full backpressure.
- Sits between the coefficient RAM read path and the write-back path of the NTT controller.

Parameters:
- DW, 16, coefficient width in bits. Must satisfy Q < 2^(DW-1).
- Q, 3329, modulus. Inputs a, b and w are required to be in [0, Q).
- LANES, 2, number of parallel butterflies.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- mode  in  2  00 NTT, 01 INTT, 10 bypass, 11 pointwise multiply. Sampled with the transaction.
- a  in  LANES*DW  first operand; lane i at bits [i*DW +: DW].
- b  in  LANES*DW  second operand; same packing as a.
- w  in  LANES*DW  per-lane twiddle; same packing as a.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- c  out  LANES*DW  first result, packed like a.
- d  out  LANES*DW  second result, packed like a.
- out_mode  out  2  mode tag travelling with the result.
- busy  out  1  OR of all pipeline valid bits.

Behaviour:
- Reset:
  - Active while rst_n = 0, sampled on the clk edge.
  - Clears every stage valid bit and every data and mode register to 0.
  - After reset: out_valid = 0, c = 0, d = 0, out_mode = 0, busy = 0, in_ready = 1.
  - A reset mid-stream discards all in-flight transactions; nothing is emitted for them.
- Arithmetic per lane (all results in [0, Q)):
  - NTT (00): t = b*w mod Q; c = (a + t) mod Q; d = (a - t) mod Q.
  - INTT (01): c = (a + b) mod Q; d = ((a - b) mod Q) * w mod Q.
  - Bypass (10): c = a; d = b. No reduction is applied.
  - Pointwise (11): c = a*w mod Q; d = b*w mod Q.
  - Full 2*DW-bit products are formed; no truncation before reduction.
- Pipeline:
  - Fixed 4 stages (localparam LAT = 4), identical for all modes. Modes are delay-equalised internally.
  - A transaction accepted at edge N, with no stall, has out_valid = 1 after edge N+4.
- Stall rule:
  - en = !out_valid || out_ready.
  - in_ready = en. The input is accepted when in_valid && in_ready.
  - All stages advance together when en = 1. When en = 0, all stages hold.
  - Bubbles occupy stage slots and are not collapsed.
  - While out_valid && !out_ready, c, d and out_mode hold stable.
- Ordering: results are strictly in acceptance order.
- Out-of-range inputs (value >= Q): output is undefined but must not corrupt other lanes or later transactions.
- Simultaneous accept and emit in one cycle is legal and gives full throughput: one transaction per cycle.

Optional Feature:
- Macro: BF_INTT_HALVE_EN.
- When defined:
  - In INTT mode, c and d are additionally multiplied by 2^-1 mod Q: x' = (x even) ? x>>1 : (x+Q)>>1.
  - This is absorbed into existing stages; latency is still 4.
  - Other modes are unaffected.
- When undefined: INTT outputs are unscaled and the halving logic is absent.

Decomposition:
- Package bf_pkg holds:
  - the mode encoding constants (MODE_NTT, MODE_INTT, MODE_BP, MODE_PWM);
  - the default Q;
  - the Barrett constant floor(2^(2*DW)/Q);
  - LAT.
- Sub-module mod_mul_q(DW, Q): 2-stage registered modular multiplier with enable, instantiated twice per lane.
  - Stage 1 forms the product; stage 2 does the Barrett reduction plus final conditional subtract.

Test Plan (Q=3329, DW=16, LANES=2, out_ready=1 unless stated):
- NTT: lane0 a=1, b=2, w=17 -> c=35, d=3296 at edge N+4. Lane1 a=0, b=0, w=5 -> c=0, d=0.
- INTT without macro: a=100, b=3300, w=2 -> c=71, d=258. With BF_INTT_HALVE_EN: c=1700, d=129.
- Pointwise: a=3328, b=2, w=3328 -> c=1, d=3327. Bypass: a=5, b=7 -> c=5, d=7 with latency 4. out_mode echoes the input mode.
- Backpressure:
  - Stream 8 back-to-back NTT transactions with out_ready=0 for 3 cycles mid-stream.
  - Expected: in_ready drops the same cycle; c and d stay stable; all 8 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 in flight -> next cycle out_valid=0, busy=0, c=d=0; no stale result ever appears.
- Random regression: 10k random in-range transactions across all modes with random in_valid/out_ready, checked against a scoreboard model.
